bh_rollback_ctrl: RTL
=====================

// Module: bh_rollback_ctrl
// PURPOSE
//  Sequencer for the gshare predictor. Keeps an in-order checkpoint queue of the
//  global history (GHT) seen by each in-flight branch. Pops one entry per retired
//  branch. On a retire-time mispredict it drives the predictor's rollback inputs
//  for exactly one cycle, flushes the queue and stalls fetch.
//  Sits between the fetch stage / retire stage and GSHARE.
// PARAMETERS
//  BH_SIZE    8   GHT width; equals `BH_SIZE
//  OBQ_DEPTH  16  checkpoint entries; power of 2, >= 2
//  PC_W       32  PC width
// PORTS
//  clock            in   1                  single clock, posedge
//  reset            in   1                  synchronous, active-high
//  if_branch_in     in   1                  fetch has a branch this cycle
//  if_pc_in         in   PC_W               fetch PC of that branch
//  gs_ght_in        in   BH_SIZE            GSHARE ght_out (history before this prediction)
//  rt_branch_valid  in   1                  a branch retires this cycle
//  rt_mispredict    in   1                  retiring branch was mispredicted (qualified by valid)
//  rt_pc_in         in   PC_W               PC of retiring branch
//  bh_tag_out       out  $clog2(OBQ_DEPTH)  slot index allocated to the fetch branch
//  fetch_stall_out  out  1                  fetch must hold
//  gs_enable_out    out  1                  GSHARE enable
//  gs_clear_en_out  out  1                  GSHARE clear_en
//  gs_obq_valid_out out  1                  GSHARE obq_bh_pred_valid
//  gs_obq_gh_out    out  BH_SIZE            GSHARE obq_gh_in
//  gs_rt_pc_out     out  PC_W               GSHARE rt_pc
//  count_out        out  $clog2(OBQ_DEPTH)+1  live entries
//  err_underflow    out  1                  sticky: retire seen while queue empty
// BEHAVIOUR
//  Reset: queue empty (head=tail=0, count=0), state IDLE.
//   All outputs 0 except gs_enable_out=1. err_underflow cleared.
//  Full/empty come from the registered count.
//   fetch_stall_out = full | (state != IDLE); gs_enable_out = ~fetch_stall_out.
//  Alloc: if_branch_in & ~fetch_stall_out & ~(rt_branch_valid & rt_mispredict).
//   Writes {gs_ght_in, if_pc_in} at tail, tail+1 mod OBQ_DEPTH.
//   bh_tag_out = tail (combinational, same cycle).
//   When full, alloc is refused even if a pop happens in the same cycle.
//  Pop: rt_branch_valid & ~empty & state==IDLE; head+1 mod OBQ_DEPTH.
//   Alloc + pop in the same cycle leaves count unchanged.
//   Retire with queue empty: ignored and sets err_underflow.
//  Mispredict (valid & mispredict & ~empty, in IDLE):
//   - registers head.ght into gh_q and rt_pc_in into pc_q
//   - any same-cycle alloc is dropped (wrong path)
//   - next state ROLLBACK
//  FSM:
//   IDLE -> ROLLBACK on mispredict.
//   ROLLBACK (exactly 1 cycle): gs_clear_en_out=1, gs_obq_valid_out=1,
//    gs_obq_gh_out=gh_q, gs_rt_pc_out=pc_q. Queue flushed (head=tail=0,
//    count=0) at the end of the cycle. -> RECOVER.
//   RECOVER (1 cycle): stall held while GSHARE commits the restored GHT. -> IDLE.
//   Outside ROLLBACK: gs_clear_en/gs_obq_valid = 0, gh/pc outputs = 0.
//  Retire inputs are ignored in ROLLBACK/RECOVER; the retire stage is already
//   flushed by the mispredict.
//  Latency: mispredict retire at cycle N -> clear_en at N+1 -> fetch resumes N+3.
//  Reset asserted mid-ROLLBACK/RECOVER: next cycle IDLE, empty, clear_en=0.
//  Pointers wrap modulo OBQ_DEPTH; count never exceeds OBQ_DEPTH nor goes below 0.
// STRUCTURE
//  Shared package sys_defs: obq_entry_t {logic [BH_SIZE-1:0] ght; logic [PC_W-1:0] pc;}
//   and bh_ctrl_state_e {IDLE, ROLLBACK, RECOVER}.
//  Sub-module bh_ckpt_fifo: circular buffer of obq_entry_t.
//   Ports: push, pop, flush, head data, tail index, count.
//  Top level holds the FSM, gating and GSHARE drive.
// TESTING
//  1 Reset -> count=0, stall=0, gs_enable=1, clear_en=0; hold reset 3 cycles, still 0.
//  2 Branches with ght 0x11,0x22,0x33 fetched -> tags 0,1,2, count=3;
//    3 clean retires -> count=0, clear_en never high.
//  3 Fill OBQ_DEPTH=16 -> stall=1; 17th branch not written; alloc+retire same
//    cycle while full -> count 15, tag unchanged; then alloc -> count 16.
//  4 Entries ght 0xA5,0x5A; retire head mispredict, rt_pc=0x1000 -> next cycle
//    clear_en=1, obq_gh=0xA5, rt_pc=0x1000 for exactly 1 cycle.
//    Then count=0, stall through RECOVER, fetch resumes N+3.
//  5 Mispredict retire with if_branch_in same cycle -> alloc dropped, tail=0 after flush.
//  6 Retire while empty -> err_underflow=1 sticky, count stays 0;
//    reset during ROLLBACK -> IDLE, clear_en=0 next cycle.

Source files
------------

// File: rtl/bh_rollback_ctrl_pkg.sv
// Shared types for the gshare rollback sequencer: checkpoint entry and FSM state.
package bh_rollback_ctrl_pkg;

   localparam int BH_SIZE       = 8;
   localparam int PC_W          = 32;
   localparam int OBQ_DEPTH_DEF = 16;

   typedef struct packed {
      logic [BH_SIZE-1:0] ght;
      logic [PC_W-1:0]    pc;
   } obq_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      ROLLBACK,
      RECOVER
   } bh_ctrl_state_e;

endpackage

// File: rtl/bh_rollback_ctrl_if.sv
// Fetch/retire/GSHARE signal bundle around the rollback sequencer.
interface bh_rollback_ctrl_if
   import bh_rollback_ctrl_pkg::*;
#(
   parameter int OBQ_DEPTH = OBQ_DEPTH_DEF
);
   localparam int TAG_W = $clog2(OBQ_DEPTH);

   logic               if_branch_in;
   logic [PC_W-1:0]    if_pc_in;
   logic [BH_SIZE-1:0] gs_ght_in;
   logic               rt_branch_valid;
   logic               rt_mispredict;
   logic [PC_W-1:0]    rt_pc_in;
   logic [TAG_W-1:0]   bh_tag_out;
   logic               fetch_stall_out;
   logic               gs_enable_out;
   logic               gs_clear_en_out;
   logic               gs_obq_valid_out;
   logic [BH_SIZE-1:0] gs_obq_gh_out;
   logic [PC_W-1:0]    gs_rt_pc_out;
   logic [TAG_W:0]     count_out;
   logic               err_underflow;

   modport master (
      output if_branch_in, if_pc_in, gs_ght_in, rt_branch_valid, rt_mispredict, rt_pc_in,
      input  bh_tag_out, fetch_stall_out, gs_enable_out, gs_clear_en_out, gs_obq_valid_out,
             gs_obq_gh_out, gs_rt_pc_out, count_out, err_underflow
   );

   modport slave (
      input  if_branch_in, if_pc_in, gs_ght_in, rt_branch_valid, rt_mispredict, rt_pc_in,
      output bh_tag_out, fetch_stall_out, gs_enable_out, gs_clear_en_out, gs_obq_valid_out,
             gs_obq_gh_out, gs_rt_pc_out, count_out, err_underflow
   );

endinterface

// File: rtl/bh_rollback_ctrl_ckpt_fifo.sv
// Circular checkpoint buffer of obq_entry_t; caller guarantees no push when full / pop when empty.
module bh_rollback_ctrl_ckpt_fifo
   import bh_rollback_ctrl_pkg::*;
#(
   parameter int DEPTH = OBQ_DEPTH_DEF,
   localparam int TAG_W = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  obq_entry_t       i_wdata,
   output obq_entry_t       o_head,
   output logic [TAG_W-1:0] o_tail,
   output logic [TAG_W:0]   o_count
);

   obq_entry_t       r_mem [DEPTH];
   logic [TAG_W-1:0] r_head;
   logic [TAG_W-1:0] r_tail;
   logic [TAG_W:0]   r_count;

   always_ff @(posedge i_clk) begin
      if (i_push) begin
         r_mem[r_tail] <= i_wdata;
      end
   end

   // Power-of-two depth: pointers wrap by natural overflow.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_tail <= r_tail + 1'b1;
         if (i_pop)  r_head <= r_head + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_head];
   assign o_tail  = r_tail;
   assign o_count = r_count;

endmodule

// File: rtl/bh_rollback_ctrl.sv
// Gshare history checkpoint sequencer: in-order GHT queue, one-cycle rollback drive, fetch stall.
module bh_rollback_ctrl
   import bh_rollback_ctrl_pkg::*;
#(
   parameter int OBQ_DEPTH = OBQ_DEPTH_DEF
) (
   input logic                clock,
   input logic                reset,
   bh_rollback_ctrl_if.slave  bus
);

   localparam int TAG_W = $clog2(OBQ_DEPTH);
   localparam int CNT_W = TAG_W + 1;

   bh_ctrl_state_e     r_state;
   logic               r_clear_en;
   logic [BH_SIZE-1:0] r_gh;
   logic [PC_W-1:0]    r_pc;
   logic               r_err;

   obq_entry_t         w_head;
   obq_entry_t         w_wdata;
   logic [TAG_W-1:0]   w_tail;
   logic [CNT_W-1:0]   w_count;
   logic               w_full;
   logic               w_empty;
   logic               w_idle;
   logic               w_stall;
   logic               w_push;
   logic               w_pop;
   logic               w_rollback;
   logic               w_flush;
   logic               w_unused_head_pc;

   assign w_full     = (w_count == CNT_W'(OBQ_DEPTH));
   assign w_empty    = (w_count == '0);
   assign w_idle     = (r_state == IDLE);
   assign w_stall    = w_full | ~w_idle;
   // A retiring mispredict squashes the same-cycle fetch even before its pop qualifies.
   assign w_push     = bus.if_branch_in & ~w_stall & ~(bus.rt_branch_valid & bus.rt_mispredict);
   assign w_pop      = bus.rt_branch_valid & ~w_empty & w_idle;
   assign w_rollback = w_pop & bus.rt_mispredict;
   assign w_flush    = (r_state == ROLLBACK);
   assign w_wdata    = '{ght: bus.gs_ght_in, pc: bus.if_pc_in};

   assign w_unused_head_pc = ^w_head.pc;

   bh_rollback_ctrl_ckpt_fifo #(
      .DEPTH (OBQ_DEPTH)
   ) u_fifo (
      .i_clk   (clock),
      .i_rst   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_wdata (w_wdata),
      .o_head  (w_head),
      .o_tail  (w_tail),
      .o_count (w_count)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= IDLE;
         r_clear_en <= 1'b0;
         r_gh       <= '0;
         r_pc       <= '0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_rollback) begin
                  r_state    <= ROLLBACK;
                  r_clear_en <= 1'b1;
                  r_gh       <= w_head.ght;
                  r_pc       <= bus.rt_pc_in;
               end
               if (bus.rt_branch_valid && w_empty) r_err <= 1'b1;
            end
            ROLLBACK: begin
               r_state    <= RECOVER;
               r_clear_en <= 1'b0;
               r_gh       <= '0;
               r_pc       <= '0;
            end
            RECOVER: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.bh_tag_out       = w_tail;
   assign bus.fetch_stall_out  = w_stall;
   assign bus.gs_enable_out    = ~w_stall;
   assign bus.gs_clear_en_out  = r_clear_en;
   assign bus.gs_obq_valid_out = r_clear_en;
   assign bus.gs_obq_gh_out    = r_gh;
   assign bus.gs_rt_pc_out     = r_pc;
   assign bus.count_out        = w_count;
   assign bus.err_underflow    = r_err;

endmodule
